// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment scan driver.
// Tear-free frame snapshot, anode guard time, leading-zero blanking,
// per-digit blink and decimal-point drive.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          scan enable (0: outputs dark, counters hold)
//   load            strobe: capture bcd_in / dp_in / blink_mask
//   bcd_in          packed BCD digits, digit 0 rightmost at [3:0]
//   dp_in           decimal point per digit
//   blink_mask      digits that blink
//   blank_lz        leading-zero blanking enable (live level)
//   seg             segments {g,f,e,d,c,b,a}, registered
//   dp              decimal point, registered
//   an              anode enables, registered
//   frame_tick      one-cycle pulse after each frame wrap
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 500,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_FRAMES - 1);

    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    // Scan state
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    // Shadow (captured on load) and display (frame-stable) copies
    logic [4*NUM_DIGITS-1:0] sh_bcd, dv_bcd;
    logic [NUM_DIGITS-1:0]   sh_dp, dv_dp;
    logic [NUM_DIGITS-1:0]   sh_blink, dv_blink;
    logic                    pending;

    logic slot_end;
    logic frame_end;

    assign slot_end  = enable && (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Active-low canonical segment patterns; 10..15 decode to blank.
    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Slot / digit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (idx == IDX_LAST)
                    idx <= '0;
                else
                    idx <= idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Blink phase toggles every BLINK_FRAMES frame wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Shadow/display transfer. A load landing exactly on the wrap
    // goes straight to the display so it is not delayed a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_bcd   <= '0;
            sh_dp    <= '0;
            sh_blink <= '0;
            dv_bcd   <= '0;
            dv_dp    <= '0;
            dv_blink <= '0;
            pending  <= 1'b0;
        end else begin
            if (load) begin
                sh_bcd   <= bcd_in;
                sh_dp    <= dp_in;
                sh_blink <= blink_mask;
            end
            if (frame_end && load) begin
                dv_bcd   <= bcd_in;
                dv_dp    <= dp_in;
                dv_blink <= blink_mask;
                pending  <= 1'b0;
            end else if (frame_end && pending) begin
                dv_bcd   <= sh_bcd;
                dv_dp    <= sh_dp;
                dv_blink <= sh_blink;
                pending  <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // lz[k]: digit k and every digit above it are zero
    logic [NUM_DIGITS-1:0] lz;
    logic [NUM_DIGITS-1:0] lz_blank;

    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = (dv_bcd[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            lz[i] = (dv_bcd[4*i +: 4] == 4'd0) && lz[i+1];
    end

    always_comb begin
        lz_blank = blank_lz ? lz : '0;
        lz_blank[0] = 1'b0;
    end

    // Current-digit selection
    logic [3:0]            cur_bcd;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  cur_lz;
    logic [NUM_DIGITS-1:0] onehot;

    always_comb begin
        cur_bcd   = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_bcd   = dv_bcd[4*i +: 4];
                cur_dp    = dv_dp[i];
                cur_blink = dv_blink[i];
                cur_lz    = lz_blank[i];
                onehot[i] = 1'b1;
            end
        end
    end

    // Next output values
    logic [6:0]            seg_nx;
    logic                  dp_nx;
    logic [NUM_DIGITS-1:0] an_nx;
    logic                  blink_hide;
    logic [6:0]            pat;

    always_comb begin
        seg_nx     = SEG_OFF;
        dp_nx      = DP_OFF;
        an_nx      = AN_OFF;
        blink_hide = blink_off && cur_blink;
        pat        = dec7(cur_bcd);
        if (!SEG_ACTIVE_LOW)
            pat = ~pat;
        if (enable) begin
            if (!blink_hide && !cur_lz)
                seg_nx = pat;
            // dp ignores leading-zero blanking but obeys blink
            if (!blink_hide && cur_dp)
                dp_nx = ~DP_OFF;
            if (cnt >= CNT_GUARD)
                an_nx = AN_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nx;
            dp         <= dp_nx;
            an         <= an_nx;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver
// NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2, active-low.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (8),
        .GUARD         (2),
        .BLINK_FRAMES  (2),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .blink_mask(blink_mask),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an_e,
                           input logic [6:0] seg_e, input logic dp_e);
        chk({tag, ".an"}, {4'h0, an}, {4'h0, an_e});
        chk({tag, ".seg"}, {1'b0, seg}, {1'b0, seg_e});
        chk({tag, ".dp"}, {7'h0, dp}, {7'h0, dp_e});
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        bcd_in     = 16'h0000;
        dp_in      = 4'h0;
        blink_mask = 4'h0;
        blank_lz   = 1'b0;
        tick(2);
        chk_out("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset.ft", {7'h0, frame_tick}, 8'h0);

        // Scan start: cycle numbers count edges after reset release
        rst    = 1'b0;
        enable = 1'b1;
        tick(1);
        chk("c1.an", {4'h0, an}, 8'h0F);
        tick(1);
        chk("c2.an", {4'h0, an}, 8'h0F);
        tick(1);
        chk_out("c3", 4'hE, 7'h40, 1'b1);
        tick(5);
        chk("c8.an", {4'h0, an}, 8'h0E);
        tick(1);
        chk("c9.an", {4'h0, an}, 8'h0F);
        tick(2);
        chk_out("c11", 4'hD, 7'h40, 1'b1);
        tick(20);
        chk("c31.ft", {7'h0, frame_tick}, 8'h0);
        tick(1);
        chk("c32.ft", {7'h0, frame_tick}, 8'h1);
        tick(1);
        chk("c33.ft", {7'h0, frame_tick}, 8'h0);

        // Mid-frame load of 1234: held off until next frame
        bcd_in = 16'h1234;
        dp_in  = 4'b0100;
        load   = 1'b1;
        tick(1);
        load = 1'b0;
        tick(25);
        chk_out("c59.old_d3", 4'h7, 7'h40, 1'b1);
        tick(8);
        chk_out("c67.d0", 4'hE, 7'h19, 1'b1);
        tick(16);
        chk_out("c83.d2", 4'hB, 7'h24, 1'b0);
        tick(8);
        chk_out("c91.d3", 4'h7, 7'h79, 1'b1);

        // Leading-zero blanking on 0050
        bcd_in   = 16'h0050;
        dp_in    = 4'h0;
        blank_lz = 1'b1;
        load     = 1'b1;
        tick(1);
        load = 1'b0;
        tick(7);
        chk_out("lz.d0", 4'hE, 7'h40, 1'b1);
        tick(8);
        chk_out("lz.d1", 4'hD, 7'h12, 1'b1);
        tick(8);
        chk_out("lz.d2", 4'hB, 7'h7F, 1'b1);
        tick(8);
        chk_out("lz.d3", 4'h7, 7'h7F, 1'b1);
        blank_lz = 1'b0;
        tick(1);
        chk_out("nolz.d3", 4'h7, 7'h40, 1'b1);

        // Load exactly on the wrap edge (cycle 128)
        tick(3);
        bcd_in = 16'h9999;
        load   = 1'b1;
        tick(1);
        load = 1'b0;
        chk("c128.ft", {7'h0, frame_tick}, 8'h1);
        tick(3);
        chk_out("byp.d0", 4'hE, 7'h10, 1'b1);
        tick(24);
        chk_out("byp.d3", 4'h7, 7'h10, 1'b1);

        // Non-BCD nibble decodes blank
        bcd_in = 16'h0A00;
        load   = 1'b1;
        tick(1);
        load = 1'b0;
        tick(23);
        chk_out("hexA.d2", 4'hB, 7'h7F, 1'b1);

        // Pause for 10 cycles mid-slot (idx=2, cnt=3 held)
        enable = 1'b0;
        tick(1);
        chk_out("pause.first", 4'hF, 7'h7F, 1'b1);
        tick(9);
        chk_out("pause.last", 4'hF, 7'h7F, 1'b1);
        chk("pause.ft", {7'h0, frame_tick}, 8'h0);
        enable = 1'b1;
        tick(1);
        chk("resume.an", {4'h0, an}, 8'h0B);
        tick(4);
        chk("resume.slot_end", {4'h0, an}, 8'h0B);
        tick(1);
        chk("resume.guard", {4'h0, an}, 8'h0F);
        tick(2);
        chk_out("resume.d3", 4'h7, 7'h40, 1'b1);
        tick(5);
        chk("resume.ft", {7'h0, frame_tick}, 8'h1);

        // Pending load discarded by reset mid-scan
        bcd_in = 16'h1111;
        load   = 1'b1;
        tick(1);
        load = 1'b0;
        rst  = 1'b1;
        tick(1);
        chk_out("rst.mid", 4'hF, 7'h7F, 1'b1);
        chk("rst.ft", {7'h0, frame_tick}, 8'h0);
        rst = 1'b0;
        tick(3);
        chk_out("rst.discard", 4'hE, 7'h40, 1'b1);

        // Blink on digit 0, half-period 64 cycles
        bcd_in     = 16'h1238;
        dp_in      = 4'b0001;
        blink_mask = 4'b0001;
        load       = 1'b1;
        tick(1);
        load = 1'b0;
        tick(31);
        chk_out("blk.vis1", 4'hE, 7'h00, 1'b0);
        tick(32);
        chk_out("blk.off1", 4'hE, 7'h7F, 1'b1);
        tick(8);
        chk_out("blk.d1", 4'hD, 7'h30, 1'b1);
        tick(24);
        chk_out("blk.off2", 4'hE, 7'h7F, 1'b1);
        tick(32);
        chk_out("blk.vis2", 4'hE, 7'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed N-digit seven-segment display driver for the chronometer display path. Takes a packed vector of BCD digits, snapshots it tear-free at frame boundaries, and scans one digit at a time onto shared segment lines with per-digit anode enables. Adds anode guard time, leading-zero blanking, per-digit blink, and decimal-point drive. Sits between the chronometer counters and the board's display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (legal 1..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (must be > GUARD+1)
- GUARD, 500, cycles at the start of each slot with all anodes inactive
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥1)
- SEG_ACTIVE_LOW, 1, 1: segment/dp lit = 0; 0: lit = 1
- AN_ACTIVE_LOW, 1, 1: anode active = 0; 0: active = 1

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  scan enable
- load  in  1  single-cycle strobe: capture bcd_in/dp_in/blink_mask
- bcd_in  in  4*NUM_DIGITS  digit i at [4i+3:4i], digit 0 = least significant/rightmost
- dp_in  in  NUM_DIGITS  decimal point per digit
- blink_mask  in  NUM_DIGITS  digits that blink
- blank_lz  in  1  leading-zero blanking enable (level, not captured)
- seg  out  7  segments {g,f,e,d,c,b,a}, registered
- dp  out  1  decimal point, registered
- an  out  NUM_DIGITS  anode enables, one-hot or none, registered
- frame_tick  out  1  one-cycle pulse at each frame wrap, registered

## Operation
- Decode per digit: 0–9 standard patterns (active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000); 10–15 blank. SEG_ACTIVE_LOW=0 inverts.
- Shadow register: on load, shadow <= inputs, pending <= 1.
- Display register: at frame boundary, if pending, display <= shadow, pending <= 0. If load coincides with a boundary, display <= inputs directly (bypass), pending <= 0.
- Slot counter cnt 0..REFRESH_DIV-1; at cnt=REFRESH_DIV-1, cnt <= 0 and digit index idx increments; wrap NUM_DIGITS-1 -> 0 is the frame boundary.
- Leading-zero blanking (blank_lz=1): digit k blanked when it and all digits above it are 0; digit 0 never blanked. dp still follows dp_in.
- Blink: frame counter toggles blink phase every BLINK_FRAMES boundaries; in off phase, digits with display blink_mask bit set show seg and dp off (anode still driven).
- an: slot idx active only when cnt ≥ GUARD; otherwise all inactive.
- enable=0: cnt, idx, blink counters hold; an all inactive, seg/dp off, frame_tick 0; load still captured; boundary transfer does not occur.

## Timing
- Reset values: seg all off (1111111 when active-low), dp off, an all inactive, frame_tick 0, cnt=0, idx=0, blink phase visible, blink frame count 0, shadow=display=0, pending=0.
- Outputs registered: an/seg/dp reflect the cnt/idx of the previous cycle (1-cycle latency).
- After reset release with enable=1: first anode (digit 0) active at cycle GUARD+1; held REFRESH_DIV-GUARD cycles.
- frame_tick high the cycle after the wrap (with idx=0, cnt=0 state); period NUM_DIGITS*REFRESH_DIV.
- New data visible no later than the start of the frame following load; never mid-frame.
- Blink half-period = BLINK_FRAMES*NUM_DIGITS*REFRESH_DIV cycles.
- rst mid-scan: next cycle all state at reset values; pending load discarded.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2, active-low.
- Reset then enable=1 -> an=1111 cycles 1–2, an=1110 cycles 3–8, an=1101 from cycle 9+2; frame_tick every 32 cycles.
- load bcd_in=16'h1234 mid-frame -> old value held until boundary; next frame digit 3 seg=1111001, digit 0 seg=0011001.
- bcd_in=16'h0050, blank_lz=1 -> digit3 blank, digit2 blank, digit1=0010010, digit0=1000000; blank_lz=0 -> digit3 shows 1000000.
- blink_mask=4'b0001 -> digit 0 seg=1111111 for 64 cycles, visible 64 cycles, alternating; others steady.
- load asserted on boundary cycle with 16'h9999 -> that frame shows 9s; bcd 4'hA on a digit -> blank.
- enable=0 mid-slot for 10 cycles -> an all inactive, counters frozen, scan resumes at same idx/cnt; rst mid-scan -> reset values next cycle.
